// File: rtl/neko_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : neko_mem_responder_if
// Purpose  : LSU <-> memory responder request/ack bundle with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface neko_mem_responder_if #(
    parameter int MEMORY_BUS_WIDTH = 32
);
    logic                        mem_rd_en;
    logic                        mem_wr_en;
    logic [31:0]                 mem_addr;
    logic [MEMORY_BUS_WIDTH-1:0] mem_wr_data;
    logic [6:0]                  mem_tag_req;
    logic                        mem_gm_or_lds;
    logic                        mem_ack;
    logic [6:0]                  mem_tag_resp;
    logic [MEMORY_BUS_WIDTH-1:0] mem_rd_data;
    logic                        req_full;
    logic                        resp_idle;
    logic [1:0]                  err_sticky;

    modport master (
        output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_tag_req, mem_gm_or_lds,
        input  mem_ack, mem_tag_resp, mem_rd_data, req_full, resp_idle, err_sticky
    );

    modport slave (
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_tag_req, mem_gm_or_lds,
        output mem_ack, mem_tag_resp, mem_rd_data, req_full, resp_idle, err_sticky
    );
endinterface
`default_nettype wire

// File: rtl/neko_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : neko_mem_responder
// Purpose  : In-order memory model behind the LSU: request FIFO, per-space latency, GM/LDS arrays.
// Revision : 1.0 - initial release
// ============================================================================
module neko_mem_responder #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int ADDR_WIDTH       = 10,
    parameter int GM_LATENCY       = 4,
    parameter int LDS_LATENCY      = 1,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    neko_mem_responder_if.slave  bus
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int MAX_LAT   = (GM_LATENCY > LDS_LATENCY) ? GM_LATENCY : LDS_LATENCY;
    localparam int LAT_W     = $clog2(MAX_LAT + 1);
    localparam int MEM_WORDS = 1 << ADDR_WIDTH;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [LAT_W-1:0] GM_LAT_M1  = LAT_W'(GM_LATENCY - 1);
    localparam logic [LAT_W-1:0] LDS_LAT_M1 = LAT_W'(LDS_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Request FIFO payload
    logic                        fifo_wr_q   [FIFO_DEPTH];
    logic                        fifo_gm_q   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]       fifo_idx_q  [FIFO_DEPTH];
    logic [MEMORY_BUS_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [6:0]                  fifo_tag_q  [FIFO_DEPTH];

    logic [MEMORY_BUS_WIDTH-1:0] gm_mem_q  [MEM_WORDS];
    logic [MEMORY_BUS_WIDTH-1:0] lds_mem_q [MEM_WORDS];

    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    state_t                      state_q, state_d;
    logic [LAT_W-1:0]            lat_cnt_q, lat_cnt_d;

    logic                        cur_wr_q, cur_wr_d;
    logic                        cur_gm_q, cur_gm_d;
    logic [ADDR_WIDTH-1:0]       cur_idx_q, cur_idx_d;
    logic [MEMORY_BUS_WIDTH-1:0] cur_data_q, cur_data_d;
    logic [6:0]                  cur_tag_q, cur_tag_d;

    logic                        mem_ack_q, mem_ack_d;
    logic [6:0]                  tag_resp_q, tag_resp_d;
    logic [MEMORY_BUS_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                        resp_idle_q, resp_idle_d;
    logic [1:0]                  err_q, err_d;

    logic                        req_valid;
    logic                        req_both;
    logic                        req_full;
    logic                        misalign;
    logic                        push;
    logic                        pop;
    logic [LAT_W-1:0]            head_lat_m1;
    logic [MEMORY_BUS_WIDTH-1:0] array_word;

    assign req_valid   = bus.mem_rd_en ^ bus.mem_wr_en;
    assign req_both    = bus.mem_rd_en & bus.mem_wr_en;
    assign req_full    = (count_q == FULL_COUNT);
    assign misalign    = (bus.mem_addr[1:0] != 2'b00);
    assign push        = req_valid & ~req_full;
    assign pop         = (count_q != '0) && ((state_q == ST_IDLE) || (state_q == ST_RESP));
    assign head_lat_m1 = fifo_gm_q[rd_ptr_q] ? GM_LAT_M1 : LDS_LAT_M1;
    assign array_word  = cur_gm_q ? gm_mem_q[cur_idx_q] : lds_mem_q[cur_idx_q];

    // Address bits above the array index only select an alias of the same word.
    generate
        if (ADDR_WIDTH + 2 < 32) begin : g_addr_high
            logic addr_high_unused;
            assign addr_high_unused = ^bus.mem_addr[31:ADDR_WIDTH+2];
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        cur_wr_d   = cur_wr_q;
        cur_gm_d   = cur_gm_q;
        cur_idx_d  = cur_idx_q;
        cur_data_d = cur_data_q;
        cur_tag_d  = cur_tag_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (pop) begin
                    cur_wr_d   = fifo_wr_q[rd_ptr_q];
                    cur_gm_d   = fifo_gm_q[rd_ptr_q];
                    cur_idx_d  = fifo_idx_q[rd_ptr_q];
                    cur_data_d = fifo_data_q[rd_ptr_q];
                    cur_tag_d  = fifo_tag_q[rd_ptr_q];
                    // Latency of one skips WAIT entirely.
                    if (head_lat_m1 == '0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d   = ST_WAIT;
                        lat_cnt_d = head_lat_m1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_ack_d   = (state_q == ST_RESP);
        tag_resp_d  = mem_ack_d ? cur_tag_q : 7'd0;
        rd_data_d   = (mem_ack_d && !cur_wr_q) ? array_word : '0;
        resp_idle_d = (count_d == '0) && (state_d == ST_IDLE);
        err_d       = err_q | {push & misalign, req_both | (req_valid & req_full)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            cur_wr_q    <= 1'b0;
            cur_gm_q    <= 1'b0;
            cur_idx_q   <= '0;
            cur_data_q  <= '0;
            cur_tag_q   <= 7'd0;
            mem_ack_q   <= 1'b0;
            tag_resp_q  <= 7'd0;
            rd_data_q   <= '0;
            resp_idle_q <= 1'b1;
            err_q       <= 2'b00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            cur_wr_q    <= cur_wr_d;
            cur_gm_q    <= cur_gm_d;
            cur_idx_q   <= cur_idx_d;
            cur_data_q  <= cur_data_d;
            cur_tag_q   <= cur_tag_d;
            mem_ack_q   <= mem_ack_d;
            tag_resp_q  <= tag_resp_d;
            rd_data_q   <= rd_data_d;
            resp_idle_q <= resp_idle_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr_q[wr_ptr_q]   <= bus.mem_wr_en;
            fifo_gm_q[wr_ptr_q]   <= bus.mem_gm_or_lds;
            fifo_idx_q[wr_ptr_q]  <= bus.mem_addr[ADDR_WIDTH+1:2];
            fifo_data_q[wr_ptr_q] <= bus.mem_wr_data;
            fifo_tag_q[wr_ptr_q]  <= bus.mem_tag_req;
        end
    end

    // Writes land on the ack edge, so a later read in the queue always sees them.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == ST_RESP) && cur_wr_q) begin
            if (cur_gm_q) begin
                gm_mem_q[cur_idx_q] <= cur_data_q;
            end else begin
                lds_mem_q[cur_idx_q] <= cur_data_q;
            end
        end
    end

    assign bus.mem_ack      = mem_ack_q;
    assign bus.mem_tag_resp = tag_resp_q;
    assign bus.mem_rd_data  = rd_data_q;
    assign bus.req_full     = req_full;
    assign bus.resp_idle    = resp_idle_q;
    assign bus.err_sticky   = err_q;

endmodule
`default_nettype wire
